ps2_host_tx: RTL and testbench

PS/2 host-to-device transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the attached keyboard using the PS/2 host-to-device protocol. It is the opposite direction of the existing PS/2 keyboard receive path.
- It drives open-drain enables for the shared PS2_CLK/PS2_DATA lines; the top level ties these onto the `inout` pins.
- It exports `busy` so the receive path ignores bus activity while a host frame is in progress.

---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_sync_filter.sv | 47 ++++
 rtl/ps2_host_tx.sv | 172 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM states, error codes and frame length.
// Used by both the host transmit and the keyboard receive paths.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    WAIT_START,
    SEND,
    WAIT_ACK,
    WAIT_IDLE
  } ps2_state_e;

  localparam logic [1:0] ERR_NONE          = 2'd0;
  localparam logic [1:0] ERR_START_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_NO_ACK        = 2'd2;
  localparam logic [1:0] ERR_FRAME_TIMEOUT = 2'd3;

  localparam int FRAME_BITS = 11;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// 2-FF synchronizer plus stability filter for a PS/2 line; emits the
// filtered level and a one-cycle pulse on each accepted falling edge.
module ps2_sync_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync_reg;
  logic          level_reg;
  logic          fall_reg;
  logic [CW-1:0] cnt_reg;
  logic          sync;

  assign sync  = sync_reg[1];
  assign level = level_reg;
  assign fall  = fall_reg;

  // Idle PS/2 lines float high, so reset to the released level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_reg  <= 2'b11;
      level_reg <= 1'b1;
      fall_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync_reg <= {sync_reg[0], raw};
      fall_reg <= 1'b0;
      if (sync == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CW'(FILTER_LEN - 1)) begin
        level_reg <= sync;
        fall_reg  <= ~sync;
        cnt_reg   <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, requests to send,
// then shifts one command byte out on device clock edges and checks the ack.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ    = 100_000_000,
  parameter int unsigned INHIBIT_CYCLES = (CLK_FREQ_HZ / 1_000_000) * 120,
  parameter int unsigned RTS_CYCLES     = (CLK_FREQ_HZ / 1_000_000) * 20,
  parameter int unsigned START_TIMEOUT  = (CLK_FREQ_HZ / 1_000) * 15,
  parameter int unsigned FRAME_TIMEOUT  = (CLK_FREQ_HZ / 1_000) * 2,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  ps2_state_e  state_reg, state_next;
  logic [31:0] timer_reg, timer_next;
  logic [3:0]  edge_cnt_reg, edge_cnt_next;
  logic [8:0]  shift_reg, shift_next;
  logic        data_oe_reg, data_oe_next;
  logic [1:0]  err_code_reg, err_code_next;
  logic        done_pulse, err_pulse;
  logic        clk_level, clk_fall;
  logic [1:0]  data_sync_reg;
  logic        data_sync;
  logic        frame_expired;

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk   (clk),
    .reset (reset),
    .raw   (ps2_clk_in),
    .level (clk_level),
    .fall  (clk_fall)
  );

  assign data_sync     = data_sync_reg[1];
  assign frame_expired = (timer_reg >= FRAME_TIMEOUT - 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      timer_reg     <= '0;
      edge_cnt_reg  <= '0;
      shift_reg     <= '0;
      data_oe_reg   <= 1'b0;
      err_code_reg  <= ERR_NONE;
      data_sync_reg <= 2'b11;
    end else begin
      state_reg     <= state_next;
      timer_reg     <= timer_next;
      edge_cnt_reg  <= edge_cnt_next;
      shift_reg     <= shift_next;
      data_oe_reg   <= data_oe_next;
      err_code_reg  <= err_code_next;
      data_sync_reg <= {data_sync_reg[0], ps2_data_in};
    end
  end

  // The timer restarts on each phase entry and again at edge 1, so after
  // that point it measures the whole frame up to the final bus-idle check.
  always_comb begin
    state_next    = state_reg;
    timer_next    = timer_reg + 32'd1;
    edge_cnt_next = edge_cnt_reg;
    shift_next    = shift_reg;
    data_oe_next  = data_oe_reg;
    err_code_next = err_code_reg;
    done_pulse    = 1'b0;
    err_pulse     = 1'b0;
    case (state_reg)
      IDLE: begin
        timer_next = '0;
        if (tx_valid) begin
          shift_next    = {odd_parity(tx_data), tx_data};
          err_code_next = ERR_NONE;
          edge_cnt_next = '0;
          state_next    = INHIBIT;
        end
      end
      INHIBIT: begin
        if (timer_reg == INHIBIT_CYCLES - 1) begin
          timer_next   = '0;
          data_oe_next = 1'b1;
          state_next   = RTS;
        end
      end
      RTS: begin
        if (timer_reg == RTS_CYCLES - 1) begin
          timer_next = '0;
          state_next = WAIT_START;
        end
      end
      WAIT_START: begin
        if (clk_fall) begin
          data_oe_next  = ~shift_reg[0];
          shift_next    = shift_reg >> 1;
          edge_cnt_next = 4'd1;
          timer_next    = '0;
          state_next    = SEND;
        end else if (timer_reg >= START_TIMEOUT - 1) begin
          err_pulse     = 1'b1;
          err_code_next = ERR_START_TIMEOUT;
        end
      end
      SEND: begin
        if (clk_fall) begin
          edge_cnt_next = edge_cnt_reg + 4'd1;
          if (edge_cnt_reg == 4'(FRAME_BITS - 2)) begin
            data_oe_next = 1'b0;
            state_next   = WAIT_ACK;
          end else begin
            data_oe_next = ~shift_reg[0];
            shift_next   = shift_reg >> 1;
          end
        end else if (frame_expired) begin
          err_pulse     = 1'b1;
          err_code_next = ERR_FRAME_TIMEOUT;
        end
      end
      WAIT_ACK: begin
        if (clk_fall) begin
          edge_cnt_next = edge_cnt_reg + 4'd1;
          if (!data_sync) begin
            state_next = WAIT_IDLE;
          end else begin
            err_pulse     = 1'b1;
            err_code_next = ERR_NO_ACK;
          end
        end else if (frame_expired) begin
          err_pulse     = 1'b1;
          err_code_next = ERR_FRAME_TIMEOUT;
        end
      end
      WAIT_IDLE: begin
        if (clk_level && data_sync) begin
          done_pulse = 1'b1;
        end else if (frame_expired) begin
          err_pulse     = 1'b1;
          err_code_next = ERR_FRAME_TIMEOUT;
        end
      end
      default: state_next = IDLE;
    endcase
    if (done_pulse || err_pulse) begin
      state_next   = IDLE;
      data_oe_next = 1'b0;
      timer_next   = '0;
    end
  end

  assign tx_ready    = (state_reg == IDLE);
  assign busy        = ~tx_ready;
  assign done        = done_pulse;
  assign err         = err_pulse;
  assign err_code    = err_pulse ? err_code_next : err_code_reg;
  assign ps2_clk_oe  = (state_reg == INHIBIT) || (state_reg == RTS);
  // Gate with the error pulse so a failure frees the bus in the same cycle.
  assign ps2_data_oe = data_oe_reg & ~err_pulse;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench: open-drain bus plus a behavioural keyboard that clocks
// frames, records the bits it reads and optionally acknowledges.
module tb_ps2_host_tx;

  localparam int INH    = 60;
  localparam int RTSC   = 20;
  localparam int STO    = 3000;
  localparam int FTO    = 4000;
  localparam int FLEN   = 4;
  localparam int HALF   = 40;
  localparam int WAIT_B = STO + FTO + 500;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, busy, done, err;
  logic [1:0] err_code;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low, dev_data_low;
  logic       ps2_clk_line, ps2_data_line;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int err_cyc = 0;
  int cyc = 0;
  logic err_oe_bad = 1'b0;
  logic both_pulse = 1'b0;

  always #5 clk = ~clk;

  assign ps2_clk_line  = !(ps2_clk_oe || dev_clk_low);
  assign ps2_data_line = !(ps2_data_oe || dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .RTS_CYCLES     (RTSC),
    .START_TIMEOUT  (STO),
    .FRAME_TIMEOUT  (FTO),
    .FILTER_LEN     (FLEN)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .err_code    (err_code),
    .ps2_clk_in  (ps2_clk_line),
    .ps2_data_in (ps2_data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: counts done/err and flags any err cycle that still drives the bus.
  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (err) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
      if (ps2_clk_oe || ps2_data_oe) err_oe_bad <= 1'b1;
    end
    if (done && err) both_pulse <= 1'b1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Keyboard view of one transaction. abort_at>0 asserts reset while the
  // device holds that clock edge low and returns without waiting for completion.
  task automatic run_frame(input logic [7:0] b, input bit clocks, input bit ack,
                           input bit hold, input int abort_at,
                           output logic [10:0] bits, output int start_lat,
                           output int d_delta, output int e_delta);
    int n, lag, w, d0, e0, rel_cyc;
    bits = '0;
    start_lat = 0;
    d_delta = 0;
    e_delta = 0;
    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge clk);
    check("ready_before", tx_ready, 1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_accept", tx_ready, 0);
    check("busy_after_accept", busy, 1);
    check("clk_oe_after_accept", ps2_clk_oe, 1);
    if (hold) tx_data = ~b;
    else tx_valid = 1'b0;
    @(negedge clk);
    n = 0;
    lag = 0;
    while (ps2_clk_oe && n < 10 * (INH + RTSC)) begin
      if (!ps2_data_oe) lag++;
      n++;
      @(negedge clk);
    end
    check("clk_oe_len", n, INH + RTSC);
    check("data_oe_lag", lag, INH);
    check("start_bit_driven", ps2_data_oe, 1);
    rel_cyc = cyc;
    if (clocks) begin
      repeat (HALF) @(negedge clk);
      for (int i = 0; i < 11; i++) begin
        bits[i] = ps2_data_line;
        if (i == 10) begin
          if (hold) tx_valid = 1'b0;
          if (ack) dev_data_low = 1'b1;
        end
        dev_clk_low = 1'b1;
        if (abort_at == i + 1) begin
          repeat (15) @(negedge clk);
          check("abort_pre_data_oe", ps2_data_oe, 1);
          rst_n = 1'b0;
          #1;
          check("abort_clk_oe", ps2_clk_oe, 0);
          check("abort_data_oe", ps2_data_oe, 0);
          dev_clk_low  = 1'b0;
          dev_data_low = 1'b0;
          tx_valid     = 1'b0;
          repeat (3) @(negedge clk);
          rst_n = 1'b1;
          return;
        end
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (HALF) @(negedge clk);
      end
      dev_data_low = 1'b0;
    end
    w = 0;
    while (done_cnt == d0 && err_cnt == e0 && w < WAIT_B) begin
      @(negedge clk);
      #1;
      w++;
    end
    check("completion_in_bound", (w < WAIT_B), 1);
    if (!clocks) start_lat = err_cyc - rel_cyc;
    repeat (2) @(negedge clk);
    #1;
    d_delta = done_cnt - d0;
    e_delta = err_cnt - e0;
  endtask

  typedef struct {
    logic [7:0] data;
    bit         clocks;
    bit         ack;
    bit         hold;
    bit         exp_parity;
    logic [1:0] exp_code;
  } vec_t;

  vec_t vecs[6];

  task automatic apply(input logic [7:0] b, input bit clocks, input bit ack, input bit hold,
                       input bit exp_par, input logic [1:0] exp_code, input string tag);
    logic [10:0] bits, exp_bits;
    int lat, dd, ed;
    run_frame(b, clocks, ack, hold, 0, bits, lat, dd, ed);
    exp_bits = {1'b1, exp_par, b, 1'b0};
    if (clocks) check({tag, "_wire_bits"}, bits, exp_bits);
    check({tag, "_done_pulses"}, dd, (exp_code == 2'd0) ? 1 : 0);
    check({tag, "_err_pulses"}, ed, (exp_code == 2'd0) ? 0 : 1);
    check({tag, "_err_code"}, err_code, exp_code);
    check({tag, "_ready_after"}, tx_ready, 1);
    check({tag, "_lines_released"}, {ps2_clk_oe, ps2_data_oe}, 0);
    if (!clocks) begin
      tests++;
      if (lat < STO - 2 || lat > STO + 2) begin
        fails++;
        $display("FAIL %s_start_latency: got %0d expected %0d", tag, lat, STO - 1);
      end
    end
    $display("[TB] %s data=%02h clocks=%0d ack=%0d hold=%0d bits=%03h done=%0d err=%0d code=%0d",
             tag, b, clocks, ack, hold, bits, dd, ed, err_code);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] bits;
    logic [7:0]  rb;
    bit          rack, rpar;
    int          lat, dd, ed;

    rst_n = 1'b0;
    tx_valid = 1'b0;
    tx_data = '0;
    dev_clk_low = 1'b0;
    dev_data_low = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done_err", {done, err}, 0);
    check("rst_err_code", err_code, 0);
    check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_ready", tx_ready, 1);

    vecs[0] = '{8'hED, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0};
    vecs[1] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0};
    vecs[3] = '{8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2};
    vecs[4] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1};
    vecs[5] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0};
    for (int i = 0; i < 6; i++)
      apply(vecs[i].data, vecs[i].clocks, vecs[i].ack, vecs[i].hold,
            vecs[i].exp_parity, vecs[i].exp_code, $sformatf("vec%0d", i));

    // Reference model: odd parity means the 9-bit payload carries an odd count of ones.
    for (int i = 0; i < 4; i++) begin
      rb   = 8'($urandom_range(0, 255));
      rack = ($urandom_range(0, 3) != 0);
      rpar = (($countones(rb) % 2) == 0);
      apply(rb, 1'b1, rack, 1'b0, rpar, rack ? 2'd0 : 2'd2, $sformatf("rnd%0d", i));
    end

    run_frame(8'h0F, 1'b1, 1'b1, 1'b0, 5, bits, lat, dd, ed);
    @(negedge clk);
    check("abort_ready", tx_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_err_code", err_code, 0);
    $display("[TB] abort data=0f reset at edge 5 ready=%0d busy=%0d", tx_ready, busy);
    apply(8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, "after_abort");

    check("err_pulse_released_bus", err_oe_bad, 0);
    check("done_err_exclusive", both_pulse, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
